// File: rtl/qblock_compositor.sv
// -----------------------------------------------------------------------------
// qblock_compositor
//
// Initiator side of a 16x16 sprite-ROM pixel interface. It converts the VGA
// scan position into local sprite coordinates (spr_ix, spr_iy), drives the
// sprite ROM, and composites the returned colour over the background where
// the ROM mask is set. It also runs the "?"-block bump animation: after a hit,
// the block rises by one pixel per frame up to BUMP_H and then falls back.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   px_x, px_y, px_de       scan position and display enable
//   frame_start             one-cycle pulse per frame, before the first pixel
//   blk_x, blk_y            block rest position, sampled at frame_start
//   bump                    one-cycle hit request
//   bg_r, bg_g, bg_b        background colour aligned with px_x/px_y
//   spr_ix, spr_iy          local column/row sent to the sprite ROM
//   spr_r, spr_g, spr_b     sprite ROM colour
//   spr_mask                sprite ROM opacity
//   out_r, out_g, out_b     composited colour, 3 clk after px_*/bg_*
//   out_de                  px_de delayed to match out_*
//   busy                    bump animation in progress
//
// Build option
//   QBLOCK_USED_DIM_EN  when defined, the block becomes "used" after its first
//                       completed bump: further bumps are ignored and opaque
//                       sprite pixels are shown at half intensity.
// -----------------------------------------------------------------------------
module qblock_compositor #(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int BUMP_H = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] px_x,
    input  logic [10:0] px_y,
    input  logic        px_de,
    input  logic        frame_start,
    input  logic [10:0] blk_x,
    input  logic [10:0] blk_y,
    input  logic        bump,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    output logic [10:0] spr_ix,
    output logic [10:0] spr_iy,
    input  logic [7:0]  spr_r,
    input  logic [7:0]  spr_g,
    input  logic [7:0]  spr_b,
    input  logic        spr_mask,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_de,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_RISE, ST_FALL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  offset_q, offset_d;
    logic        busy_q;
    logic [10:0] x0_q, y0_q;
    logic [10:0] y0_next;
    logic        bump_ok;

    // ---------------- bump animation FSM ----------------
`ifdef QBLOCK_USED_DIM_EN
    logic used_q, used_d;
    assign bump_ok = bump && !used_q;
`else
    assign bump_ok = bump;
`endif

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
`ifdef QBLOCK_USED_DIM_EN
        used_d   = used_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A bump coinciding with frame_start is accepted, but the first
                // increment waits for the following frame_start.
                if (bump_ok) state_d = ST_RISE;
            end
            ST_RISE: begin
                if (frame_start) begin
                    offset_d = offset_q + 4'd1;
                    if (offset_d == 4'(BUMP_H)) state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (frame_start) begin
                    offset_d = offset_q - 4'd1;
                    if (offset_d == 4'd0) begin
                        state_d = ST_IDLE;
`ifdef QBLOCK_USED_DIM_EN
                        used_d  = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                offset_d = 4'd0;
            end
        endcase
    end

    // Raised position, clamped at the top of the screen.
    assign y0_next = (blk_y < {7'd0, offset_d}) ? 11'd0 : (blk_y - {7'd0, offset_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            offset_q <= 4'd0;
            busy_q   <= 1'b0;
            x0_q     <= 11'd0;
            y0_q     <= 11'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            busy_q   <= (state_d != ST_IDLE);
            if (frame_start) begin
                x0_q <= blk_x;
                y0_q <= y0_next;
            end
        end
    end

`ifdef QBLOCK_USED_DIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) used_q <= 1'b0;
        else        used_q <= used_d;
    end
`endif

    // ---------------- stage 0: hit test (12-bit, no wrap) ----------------
    logic [11:0] px_x_e, px_y_e, x0_e, y0_e;
    logic        in_box;
    logic [10:0] lx, ly;

    assign px_x_e = {1'b0, px_x};
    assign px_y_e = {1'b0, px_y};
    assign x0_e   = {1'b0, x0_q};
    assign y0_e   = {1'b0, y0_q};

    assign in_box = (px_x_e >= x0_e) && (px_x_e < x0_e + 12'(SPR_W)) &&
                    (px_y_e >= y0_e) && (px_y_e < y0_e + 12'(SPR_H));
    assign lx = in_box ? (px_x - x0_q) : 11'd0;
    assign ly = in_box ? (px_y - y0_q) : 11'd0;

    // ---------------- pipeline stages 1..3 ----------------
    // The ROM registers its row from spr_iy, so the row is issued one cycle
    // ahead of the column to line both up at stage 3.
    logic [10:0] spr_ix_q, spr_iy_q, ix1_q;
    logic        inbox1_q, inbox2_q, de1_q, de2_q;
    logic [23:0] bg1_q, bg2_q;
    logic [7:0]  out_r_q, out_g_q, out_b_q;
    logic        out_de_q;
    logic [7:0]  spr_r_eff, spr_g_eff, spr_b_eff;

`ifdef QBLOCK_USED_DIM_EN
    assign spr_r_eff = used_q ? {1'b0, spr_r[7:1]} : spr_r;
    assign spr_g_eff = used_q ? {1'b0, spr_g[7:1]} : spr_g;
    assign spr_b_eff = used_q ? {1'b0, spr_b[7:1]} : spr_b;
`else
    assign spr_r_eff = spr_r;
    assign spr_g_eff = spr_g;
    assign spr_b_eff = spr_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_iy_q <= 11'd0;
            ix1_q    <= 11'd0;
            inbox1_q <= 1'b0;
            bg1_q    <= 24'd0;
            de1_q    <= 1'b0;
            spr_ix_q <= 11'd0;
            inbox2_q <= 1'b0;
            bg2_q    <= 24'd0;
            de2_q    <= 1'b0;
            out_r_q  <= 8'd0;
            out_g_q  <= 8'd0;
            out_b_q  <= 8'd0;
            out_de_q <= 1'b0;
        end else begin
            spr_iy_q <= ly;
            ix1_q    <= lx;
            inbox1_q <= in_box;
            bg1_q    <= {bg_r, bg_g, bg_b};
            de1_q    <= px_de;

            spr_ix_q <= ix1_q;
            inbox2_q <= inbox1_q;
            bg2_q    <= bg1_q;
            de2_q    <= de1_q;

            if (inbox2_q && spr_mask) begin
                out_r_q <= spr_r_eff;
                out_g_q <= spr_g_eff;
                out_b_q <= spr_b_eff;
            end else begin
                out_r_q <= bg2_q[23:16];
                out_g_q <= bg2_q[15:8];
                out_b_q <= bg2_q[7:0];
            end
            out_de_q <= de2_q;
        end
    end

    assign spr_ix = spr_ix_q;
    assign spr_iy = spr_iy_q;
    assign out_r  = out_r_q;
    assign out_g  = out_g_q;
    assign out_b  = out_b_q;
    assign out_de = out_de_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_qblock_compositor.sv
module tb_qblock_compositor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] px_x, px_y, blk_x, blk_y;
    logic        px_de, frame_start, bump, spr_mask;
    logic [7:0]  bg_r, bg_g, bg_b, spr_r, spr_g, spr_b;
    logic [10:0] spr_ix, spr_iy;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_de, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qblock_compositor dut (
        .clk(clk), .rst_n(rst_n),
        .px_x(px_x), .px_y(px_y), .px_de(px_de), .frame_start(frame_start),
        .blk_x(blk_x), .blk_y(blk_y), .bump(bump),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .spr_ix(spr_ix), .spr_iy(spr_iy),
        .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_mask(spr_mask),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_de(out_de), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1ns after.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic with_bump);
        frame_start = 1'b1;
        bump        = with_bump;
        tick(1);
        frame_start = 1'b0;
        bump        = 1'b0;
    endtask

    // Put the scan on (blk_x, py) and read back the local row the DUT issues.
    task automatic probe_row(input string tag, input logic [10:0] py, input logic [10:0] exp_iy);
        px_x = blk_x;
        px_y = py;
        tick(2);
        check(tag, {21'd0, spr_iy}, {21'd0, exp_iy});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_r"},  {24'd0, out_r}, 32'd0);
        check({tag, "_out_g"},  {24'd0, out_g}, 32'd0);
        check({tag, "_out_b"},  {24'd0, out_b}, 32'd0);
        check({tag, "_out_de"}, {31'd0, out_de}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy}, 32'd0);
        check({tag, "_spr_ix"}, {21'd0, spr_ix}, 32'd0);
        check({tag, "_spr_iy"}, {21'd0, spr_iy}, 32'd0);
    endtask

    // Expected y0 sequences, converted to local rows at the probe line.
    int t4_iy [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 0};
    int t4_bsy[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int t5_iy [8] = '{1, 2, 2, 2, 2, 2, 1, 0};
    int t5_bsy[8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        rst_n = 1'b0;
        px_x = 11'd0; px_y = 11'd0; px_de = 1'b0;
        frame_start = 1'b0; bump = 1'b0;
        blk_x = 11'd100; blk_y = 11'd50;
        bg_r = 8'h00; bg_g = 8'h00; bg_b = 8'h00;
        spr_r = 8'h00; spr_g = 8'h00; spr_b = 8'h00; spr_mask = 1'b0;

        // T1a: reset state
        #3;
        check_all_zero("rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // T2: latch block, latency and left-edge boundary
        frame(1'b0);
        px_x = 11'd99; px_y = 11'd50; px_de = 1'b1;
        bg_r = 8'h11; spr_r = 8'hA0; spr_mask = 1'b1;
        tick(4);
        check("t2_left_outside_r", {24'd0, out_r}, 32'h11);
        check("t2_de", {31'd0, out_de}, 32'd1);
        px_x = 11'd100;
        tick(2);
        check("t2_latency_hold_r", {24'd0, out_r}, 32'h11);
        tick(1);
        check("t2_inside_r", {24'd0, out_r}, 32'hA0);
        check("t2_spr_ix", {21'd0, spr_ix}, 32'd0);
        check("t2_spr_iy", {21'd0, spr_iy}, 32'd0);
        px_de = 1'b0;
        tick(3);
        check("t2_de_low", {31'd0, out_de}, 32'd0);
        px_de = 1'b1;

        // T3: transparent pixel at far corner, then right-edge outside
        px_x = 11'd115; px_y = 11'd65; spr_mask = 1'b0;
        bg_r = 8'h22; bg_g = 8'h33; bg_b = 8'h44;
        tick(4);
        check("t3_mask0_r", {24'd0, out_r}, 32'h22);
        check("t3_mask0_g", {24'd0, out_g}, 32'h33);
        check("t3_mask0_b", {24'd0, out_b}, 32'h44);
        check("t3_corner_ix", {21'd0, spr_ix}, 32'd15);
        check("t3_corner_iy", {21'd0, spr_iy}, 32'd15);
        px_x = 11'd116; spr_mask = 1'b1;
        tick(4);
        check("t3_right_outside_r", {24'd0, out_r}, 32'h22);
        check("t3_right_outside_ix", {21'd0, spr_ix}, 32'd0);
        px_x = 11'd115; px_y = 11'd66;
        tick(4);
        check("t3_below_outside_r", {24'd0, out_r}, 32'h22);

        // T4: bump animation at blk_y=50, second bump ignored
        check("t4_idle_busy", {31'd0, busy}, 32'd0);
        bump = 1'b1;
        tick(1);
        bump = 1'b0;
        check("t4_busy_after_bump", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            frame(1'b0);
            probe_row($sformatf("t4_frame%0d_row", i + 1), 11'd50, 11'(t4_iy[i]));
            check($sformatf("t4_frame%0d_busy", i + 1), {31'd0, busy}, 32'(t4_bsy[i]));
            if (i == 1) begin
                bump = 1'b1;
                tick(1);
                bump = 1'b0;
            end
        end

        // T6: used-dim behaviour after one completed bump
        px_x = 11'd100; px_y = 11'd50; spr_r = 8'hA0; spr_mask = 1'b1;
        tick(4);
`ifdef QBLOCK_USED_DIM_EN
        check("t6_dim_r", {24'd0, out_r}, 32'h50);
`else
        check("t6_plain_r", {24'd0, out_r}, 32'hA0);
`endif
        bump = 1'b1;
        tick(1);
        bump = 1'b0;
`ifdef QBLOCK_USED_DIM_EN
        check("t6_bump_ignored_busy", {31'd0, busy}, 32'd0);
`else
        check("t6_bump_repeat_busy", {31'd0, busy}, 32'd1);
        frame(1'b0);
        probe_row("t6_repeat_row", 11'd50, 11'd1);
`endif

        // T1b: reset mid-animation, asynchronously
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick(1);
        frame(1'b0);
        bump = 1'b1;
        tick(1);
        bump = 1'b0;
        frame(1'b0);
        frame(1'b0);
        px_x = 11'd101; px_y = 11'd51; spr_r = 8'hA0; spr_mask = 1'b1;
        tick(4);
        check("t1_pre_busy", {31'd0, busy}, 32'd1);
        check("t1_pre_iy", {21'd0, spr_iy}, 32'd3);
        check("t1_pre_r", {24'd0, out_r}, 32'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t1_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        frame(1'b0);
        probe_row("t1_offset_cleared_row", 11'd50, 11'd0);
        check("t1_post_busy", {31'd0, busy}, 32'd0);
        px_x = 11'd100; px_y = 11'd50;
        tick(4);
        check("t1_undimmed_r", {24'd0, out_r}, 32'hA0);

        // T5: clamped bump at blk_y=2, bump coincident with frame_start
        blk_y = 11'd2;
        frame(1'b1);
        probe_row("t5_frame0_row", 11'd2, 11'd0);
        check("t5_frame0_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            frame(1'b0);
            probe_row($sformatf("t5_frame%0d_row", i + 1), 11'd2, 11'(t5_iy[i]));
            check($sformatf("t5_frame%0d_busy", i + 1), {31'd0, busy}, 32'(t5_bsy[i]));
        end
        frame(1'b0);
        probe_row("t5_rest_row", 11'd2, 11'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
